// File: rtl/func_sweep_ctrl.sv
// Sweeps {w,x,y,z}=0..15 into two F implementations, checks both against EXP_TT after a settle window.
// Latency 16*(SETTLE+1)+1 cycles start-to-done; start is ignored while busy; abort returns to IDLE without done.
module func_sweep_ctrl #(
  parameter logic [15:0] EXP_TT = 16'h1F55,
  parameter int          SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_a_f,
  input  logic       dut_b_f,
  output logic [3:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mismatch_cnt,
  output logic       fail_valid,
  output logic [3:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt, settle_nxt;
  logic [3:0] vec_nxt;
  logic [4:0] cnt_nxt;
  logic       fv_nxt;
  logic [3:0] ffi_nxt;
  logic       pass_nxt;
  logic       exp_bit;
  logic       miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= 4'd0;
      settle_cnt     <= 4'd0;
      mismatch_cnt   <= 5'd0;
      fail_valid     <= 1'b0;
      first_fail_idx <= 4'd0;
      pass           <= 1'b0;
    end else begin
      state          <= state_nxt;
      vec            <= vec_nxt;
      settle_cnt     <= settle_nxt;
      mismatch_cnt   <= cnt_nxt;
      fail_valid     <= fv_nxt;
      first_fail_idx <= ffi_nxt;
      pass           <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    vec_nxt    = vec;
    settle_nxt = settle_cnt;
    cnt_nxt    = mismatch_cnt;
    fv_nxt     = fail_valid;
    ffi_nxt    = first_fail_idx;
    pass_nxt   = pass;
    exp_bit    = EXP_TT[vec];
    // Case inequality so an X/Z from either implementation is scored as a miss.
    miss       = (dut_a_f !== exp_bit) || (dut_b_f !== exp_bit);

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt  = HOLD;
          vec_nxt    = 4'd0;
          settle_nxt = 4'd0;
          cnt_nxt    = 5'd0;
          fv_nxt     = 1'b0;
          ffi_nxt    = 4'd0;
          pass_nxt   = 1'b0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt  = IDLE;
          vec_nxt    = 4'd0;
          settle_nxt = 4'd0;
          pass_nxt   = 1'b0;
        end else begin
          settle_nxt = settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_nxt  = IDLE;
          vec_nxt    = 4'd0;
          settle_nxt = 4'd0;
          pass_nxt   = 1'b0;
        end else begin
          if (miss) begin
            cnt_nxt = mismatch_cnt + 5'd1;
            if (!fail_valid) begin
              ffi_nxt = vec;
              fv_nxt  = 1'b1;
            end
          end
          // vec only advances on HOLD entry, so each vector is stable for SETTLE+1 cycles.
          if (vec != 4'd15) begin
            vec_nxt    = vec + 4'd1;
            settle_nxt = 4'd0;
            state_nxt  = HOLD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        pass_nxt  = (mismatch_cnt == 5'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == HOLD) || (state == CHECK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Scoreboard bench for func_sweep_ctrl: stimulus pushes expected sweep results, a monitor checks on each done.
module tb_func_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       a_f, b_f, a_f1, b_f1;
  logic [3:0] vec, vec1;
  logic       busy, done, pass, fail_valid;
  logic       busy1, done1, pass1, fail_valid1;
  logic [4:0] mismatch_cnt, mismatch_cnt1;
  logic [3:0] first_fail_idx, first_fail_idx1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;

  typedef struct {
    int         t0;
    int         lat;
    logic       pass;
    logic [4:0] cnt;
    logic       fv;
    logic [3:0] ffi;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  func_sweep_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_a_f(a_f), .dut_b_f(b_f), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .mismatch_cnt(mismatch_cnt), .fail_valid(fail_valid),
    .first_fail_idx(first_fail_idx)
  );

  func_sweep_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_a_f(a_f1), .dut_b_f(b_f1), .vec(vec1), .busy(busy1), .done(done1),
    .pass(pass1), .mismatch_cnt(mismatch_cnt1), .fail_valid(fail_valid1),
    .first_fail_idx(first_fail_idx1)
  );

  // Reference F straight from the boolean equation, independent of the truth-table constant.
  function automatic logic f_ref(input logic [3:0] v);
    return (v[3] & ~v[2]) | (~v[3] & ~v[0]) | (~v[1] & ~v[0]);
  endfunction

  always_comb begin
    a_f  = f_ref(vec);
    b_f  = f_ref(vec);
    a_f1 = f_ref(vec1);
    b_f1 = f_ref(vec1);
    case (mode)
      1: b_f = 1'b0;
      2: a_f = 1'b1;
      3: a_f = ~f_ref(vec);
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc - e.t0, e.lat);
          check("mismatch_cnt", mismatch_cnt, e.cnt);
          check("fail_valid", fail_valid, e.fv);
          check("first_fail_idx", first_fail_idx, e.ffi);
          check("busy_in_done", busy, 0);
          @(negedge clk);
          check("pass", pass, e.pass);
          check("done_one_cycle", done, 0);
        end
      end
    end
  end

  task automatic pulse_start(input logic [4:0] cnt, input logic fv, input logic [3:0] ffi,
                             input logic p, output int t0);
    exp_t e;
    @(posedge clk); #1 start = 1'b1;
    t0 = cyc;
    e.t0 = t0; e.lat = 49; e.pass = p; e.cnt = cnt; e.fv = fv; e.ffi = ffi;
    sb.push_back(e);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int n = 0;
    @(negedge clk);
    while (vec != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec", vec, v);
  endtask

  task automatic run_sweep(input int m, input logic [4:0] cnt, input logic fv,
                           input logic [3:0] ffi, input logic p);
    int t0;
    mode = m;
    pulse_start(cnt, fv, ffi, p, t0);
    wait_done(80);
  endtask

  initial begin
    int t0;
    int dwell_err;
    int seen_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_vec", vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_cnt", mismatch_cnt, 0);
    check("rst_fv", fail_valid, 0);
    check("rst_ffi", first_fail_idx, 0);

    // T1 all correct; T2 B stuck 0; T4b repeat clears counts; T3 A stuck 1; T3b A inverted
    run_sweep(0, 5'd0, 1'b0, 4'd0, 1'b1);
    run_sweep(1, 5'd9, 1'b1, 4'd0, 1'b0);
    run_sweep(1, 5'd9, 1'b1, 4'd0, 1'b0);
    run_sweep(2, 5'd7, 1'b1, 4'd1, 1'b0);
    run_sweep(3, 5'd16, 1'b1, 4'd0, 1'b0);

    // T4 start re-pulsed mid-sweep is ignored
    mode = 0;
    pulse_start(5'd0, 1'b0, 4'd0, 1'b1, t0);
    wait_vec(4'd5);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(80);

    // T5 async reset mid-HOLD at vec 7
    mode = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_vec(4'd7);
    check("t5_partial_cnt", mismatch_cnt, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_vec", vec, 0);
    check("t5_busy", busy, 0);
    check("t5_cnt", mismatch_cnt, 0);
    check("t5_fv", fail_valid, 0);
    check("t5_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T5b abort at vec 7 keeps partial counts, no done
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_vec(4'd7);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t5b_busy", busy, 0);
    check("t5b_vec", vec, 0);
    check("t5b_cnt", mismatch_cnt, 4);
    check("t5b_fv", fail_valid, 1);
    check("t5b_ffi", first_fail_idx, 0);
    check("t5b_pass", pass, 0);
    seen_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("t5b_no_done", seen_done, 0);

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);

    // T6 SETTLE=1 instance: 2-cycle dwell per vector, done at 33
    mode = 0;
    pulse_start(5'd0, 1'b0, 4'd0, 1'b1, t0);
    dwell_err = 0;
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        if (vec1 != 4'(v)) dwell_err++;
      end
    end
    check("t6_dwell_errors", dwell_err, 0);
    @(negedge clk);
    check("t6_done", done1, 1);
    check("t6_latency", cyc - t0, 33);
    wait_done(80);
    check("t6_pass", pass1, 1);
    check("t6_cnt", mismatch_cnt1, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
